// File: rtl/rx_port_arbiter_if.sv
// RX-to-core packet handshake bundle.
// slave = arbiter side, master = RX units plus core side.
interface rx_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int PTR_W     = 2
);
    logic [NUM_PORTS-1:0]        rx_valid;
    logic [NUM_PORTS*DATA_W-1:0] rx_data;
    logic                        core_ready;
    logic [NUM_PORTS-1:0]        rx_ready;
    logic                        core_valid;
    logic [DATA_W-1:0]           core_data;
    logic [PTR_W-1:0]            core_port;
    logic                        timeout_err;

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  core_ready,
        output rx_ready,
        output core_valid,
        output core_data,
        output core_port,
        output timeout_err
    );

    modport master (
        output rx_valid,
        output rx_data,
        output core_ready,
        input  rx_ready,
        input  core_valid,
        input  core_data,
        input  core_port,
        input  timeout_err
    );
endinterface

// File: rtl/rx_port_arbiter.sv
// Round-robin arbiter sharing the core packet input among RX units.
// Four-phase Valid/Ready per port, watchdog on stuck Valid.
module rx_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int PTR_W     = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    rx_port_arbiter_if.slave bus
);
    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;
    localparam logic [1:0] ST_REL   = 2'd3;

    logic [1:0]           r_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_grant;
    logic [7:0]           r_wd_cnt;
    logic [DATA_W-1:0]    r_core_data;
    logic                 r_timeout;

    logic                 w_found;
    logic [PTR_W-1:0]     w_sel;
    logic [PTR_W:0]       w_sum;
    logic [DATA_W-1:0]    w_sel_data;
    logic [PTR_W-1:0]     w_next_ptr;
    logic [7:0]           w_wd_inc;
    logic [NUM_PORTS-1:0] w_ready;

    // First requester at or after rr_ptr, wrapping below NUM_PORTS
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_PORTS)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_PORTS);
            end
            if (!w_found && bus.rx_valid[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[PTR_W-1:0];
            end
        end
    end

    // Helper values: selected data, next pointer, watchdog step
    always_comb begin
        w_sel_data = bus.rx_data[w_sel*DATA_W +: DATA_W];
        w_wd_inc   = r_wd_cnt + 8'd1;
        if (r_grant == PTR_W'(NUM_PORTS-1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = r_grant + 1'b1;
        end
    end

    // Ready only to the granted port, only in GRANT
    always_comb begin
        w_ready = '0;
        if (r_state == ST_GRANT) begin
            w_ready[r_grant] = 1'b1;
        end
    end

    // Arbitration state machine with watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RST;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_wd_cnt    <= '0;
            r_core_data <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                ST_RST: begin
                    if (!(|bus.rx_valid)) begin
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (bus.core_ready && w_found) begin
                        r_grant     <= w_sel;
                        r_core_data <= w_sel_data;
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_wd_cnt <= '0;
                    r_state  <= ST_REL;
                end
                ST_REL: begin
                    if (!bus.rx_valid[r_grant]) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_SCAN;
                    end else if (w_wd_inc == 8'(TIMEOUT)) begin
                        r_timeout <= 1'b1;
                        r_rr_ptr  <= w_next_ptr;
                        r_state   <= ST_SCAN;
                    end else begin
                        r_wd_cnt <= w_wd_inc;
                    end
                end
                default: r_state <= ST_RST;
            endcase
        end
    end

    assign bus.rx_ready    = w_ready;
    assign bus.core_valid  = (r_state == ST_GRANT);
    assign bus.core_data   = r_core_data;
    assign bus.core_port   = r_grant;
    assign bus.timeout_err = r_timeout;
endmodule

// File: tb/tb_rx_port_arbiter.sv
// Directed self-checking bench for rx_port_arbiter.
// Four ports, 8-bit data, watchdog TIMEOUT of 4.
module tb_rx_port_arbiter;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int PW = 2;
    localparam int TO = 4;
    localparam logic [1:0] S_RST   = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;
    localparam logic [1:0] S_REL   = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rx_port_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW), .PTR_W(PW)) bus ();

    rx_port_arbiter #(
        .NUM_PORTS(NP), .DATA_W(DW), .PTR_W(PW), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rx_valid = 4'b0010;
        bus.core_ready = 1'b1;
        bus.rx_data = 32'h0;
        tick();
        tick();
        checks++;
        if (dut.r_state !== S_RST) begin
            failures++;
            $display("FAIL rst_state got=%0d exp=%0d", dut.r_state, S_RST);
        end
        checks++;
        if ({bus.rx_ready, bus.core_valid, bus.timeout_err} !== 6'b0) begin
            failures++;
            $display("FAIL rst_outs got=%b exp=0",
                     {bus.rx_ready, bus.core_valid, bus.timeout_err});
        end
        checks++;
        if ({bus.core_data, bus.core_port, dut.r_rr_ptr} !== 12'h0) begin
            failures++;
            $display("FAIL rst_regs got=%h exp=0",
                     {bus.core_data, bus.core_port, dut.r_rr_ptr});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dut.r_state !== S_RST) begin
                failures++;
                $display("FAIL flush_state cyc=%0d got=%0d exp=%0d",
                         i, dut.r_state, S_RST);
            end
            checks++;
            if ({bus.rx_ready, bus.core_valid} !== 5'b0) begin
                failures++;
                $display("FAIL flush_outs cyc=%0d got=%b exp=0",
                         i, {bus.rx_ready, bus.core_valid});
            end
        end
        bus.rx_valid = 4'b0000;
        tick();
        checks++;
        if (dut.r_state !== S_SCAN) begin
            failures++;
            $display("FAIL rst_to_scan got=%0d exp=%0d", dut.r_state, S_SCAN);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.rx_valid = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.rx_data = 32'h00A5_0000;
        bus.rx_valid = 4'b0100;
        tick();
        checks++;
        if (bus.core_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_cv got=%b exp=1", bus.core_valid);
        end
        checks++;
        if (bus.core_data !== 8'hA5) begin
            failures++;
            $display("FAIL single_data got=%h exp=a5", bus.core_data);
        end
        checks++;
        if (bus.core_port !== 2'd2) begin
            failures++;
            $display("FAIL single_port got=%0d exp=2", bus.core_port);
        end
        checks++;
        if (bus.rx_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_ready got=%b exp=0100", bus.rx_ready);
        end
        tick();
        checks++;
        if ({bus.rx_ready, bus.core_valid} !== 5'b0) begin
            failures++;
            $display("FAIL single_rel got=%b exp=0",
                     {bus.rx_ready, bus.core_valid});
        end
        bus.rx_valid = 4'b0000;
        tick();
        checks++;
        if (dut.r_state !== S_SCAN) begin
            failures++;
            $display("FAIL single_scan got=%0d exp=%0d", dut.r_state, S_SCAN);
        end
        checks++;
        if (dut.r_rr_ptr !== 2'd3) begin
            failures++;
            $display("FAIL single_rr got=%0d exp=3", dut.r_rr_ptr);
        end
        checks++;
        if (bus.core_data !== 8'hA5) begin
            failures++;
            $display("FAIL single_hold got=%h exp=a5", bus.core_data);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] v;
        logic [3:0] dropm;
        logic [3:0] rearm;
        logic [1:0] exp_p;
        bit         dropnow;
        int         last;
        int         grants;
        v = 4'hF;
        dropm = 4'h0;
        rearm = 4'h0;
        dropnow = 1'b0;
        last = 0;
        grants = 0;
        bus.rx_data = 32'h0302_0100;
        bus.rx_valid = v;
        for (int c = 0; c < 40 && grants < 5; c++) begin
            tick();
            checks++;
            if ($countones(bus.rx_ready) > 1) begin
                failures++;
                $display("FAIL rr_onehot cyc=%0d got=%b exp=onehot0",
                         c, bus.rx_ready);
            end
            v = v | rearm;
            rearm = 4'h0;
            if (dropnow) begin
                v = v & ~dropm;
                rearm = dropm;
                dropnow = 1'b0;
            end
            if (bus.core_valid === 1'b1) begin
                exp_p = 2'(grants % 4);
                checks++;
                if (bus.core_port !== exp_p) begin
                    failures++;
                    $display("FAIL rr_port n=%0d got=%0d exp=%0d",
                             grants, bus.core_port, exp_p);
                end
                checks++;
                if (bus.core_data !== {6'd0, exp_p}) begin
                    failures++;
                    $display("FAIL rr_data n=%0d got=%h exp=%h",
                             grants, bus.core_data, exp_p);
                end
                if (grants > 0) begin
                    checks++;
                    if (c - last != 3) begin
                        failures++;
                        $display("FAIL rr_spacing n=%0d got=%0d exp=3",
                                 grants, c - last);
                    end
                end
                last = c;
                grants++;
                dropm = 4'b0001 << exp_p;
                dropnow = 1'b1;
            end
            bus.rx_valid = v;
        end
        checks++;
        if (grants != 5) begin
            failures++;
            $display("FAIL rr_count got=%0d exp=5", grants);
        end
        bus.rx_valid = 4'b0000;
        tick();
        tick();
        checks++;
        if (dut.r_rr_ptr !== 2'd1) begin
            failures++;
            $display("FAIL rr_ptr_end got=%0d exp=1", dut.r_rr_ptr);
        end
    endtask

    task automatic test_core_block();
        bus.core_ready = 1'b0;
        bus.rx_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({bus.rx_ready, bus.core_valid} !== 5'b0) begin
                failures++;
                $display("FAIL block_outs cyc=%0d got=%b exp=0",
                         i, {bus.rx_ready, bus.core_valid});
            end
        end
        bus.core_ready = 1'b1;
        tick();
        checks++;
        if (bus.core_valid !== 1'b1) begin
            failures++;
            $display("FAIL unblock_cv got=%b exp=1", bus.core_valid);
        end
        checks++;
        if (bus.core_port !== 2'd1) begin
            failures++;
            $display("FAIL unblock_port got=%0d exp=1", bus.core_port);
        end
        checks++;
        if (bus.rx_ready !== 4'b0010) begin
            failures++;
            $display("FAIL unblock_ready got=%b exp=0010", bus.rx_ready);
        end
        checks++;
        if (bus.core_data !== 8'h01) begin
            failures++;
            $display("FAIL unblock_data got=%h exp=01", bus.core_data);
        end
        bus.rx_valid = 4'b0000;
        tick();
        tick();
        checks++;
        if (dut.r_rr_ptr !== 2'd2) begin
            failures++;
            $display("FAIL unblock_rr got=%0d exp=2", dut.r_rr_ptr);
        end
    endtask

    task automatic test_timeout();
        bus.rx_data = 32'h3300_1100;
        bus.rx_valid = 4'b0010;
        tick();
        checks++;
        if (bus.core_port !== 2'd1 || bus.core_valid !== 1'b1) begin
            failures++;
            $display("FAIL to_grant1 got=%0d/%b exp=1/1",
                     bus.core_port, bus.core_valid);
        end
        bus.rx_valid = 4'b1010;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (dut.r_state !== S_REL || bus.timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL to_rel cyc=%0d got=%0d/%b exp=%0d/0",
                         i, dut.r_state, bus.timeout_err, S_REL);
            end
        end
        tick();
        checks++;
        if (bus.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL to_pulse got=%b exp=1", bus.timeout_err);
        end
        checks++;
        if (dut.r_state !== S_SCAN || dut.r_rr_ptr !== 2'd2) begin
            failures++;
            $display("FAIL to_scan got=%0d/%0d exp=%0d/2",
                     dut.r_state, dut.r_rr_ptr, S_SCAN);
        end
        tick();
        checks++;
        if (bus.core_valid !== 1'b1 || bus.core_port !== 2'd3) begin
            failures++;
            $display("FAIL to_next got=%b/%0d exp=1/3",
                     bus.core_valid, bus.core_port);
        end
        checks++;
        if (bus.core_data !== 8'h33 || bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL to_next_data got=%h/%b exp=33/0",
                     bus.core_data, bus.timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        checks++;
        if (dut.r_state !== S_REL) begin
            failures++;
            $display("FAIL mid_pre got=%0d exp=%0d", dut.r_state, S_REL);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.r_state !== S_RST || dut.r_rr_ptr !== 2'd0) begin
            failures++;
            $display("FAIL mid_state got=%0d/%0d exp=%0d/0",
                     dut.r_state, dut.r_rr_ptr, S_RST);
        end
        checks++;
        if (bus.core_data !== 8'h00 || bus.core_port !== 2'd0) begin
            failures++;
            $display("FAIL mid_regs got=%h/%0d exp=00/0",
                     bus.core_data, bus.core_port);
        end
        checks++;
        if ({bus.rx_ready, bus.core_valid, bus.timeout_err} !== 6'b0) begin
            failures++;
            $display("FAIL mid_outs got=%b exp=0",
                     {bus.rx_ready, bus.core_valid, bus.timeout_err});
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut.r_state !== S_RST || bus.rx_ready !== 4'b0) begin
                failures++;
                $display("FAIL mid_flush cyc=%0d got=%0d/%b exp=%0d/0",
                         i, dut.r_state, bus.rx_ready, S_RST);
            end
        end
        bus.rx_valid = 4'b0000;
        tick();
        checks++;
        if (dut.r_state !== S_SCAN) begin
            failures++;
            $display("FAIL mid_scan got=%0d exp=%0d", dut.r_state, S_SCAN);
        end
    endtask

    initial begin
        bus.rx_valid = 4'b0000;
        bus.rx_data = 32'h0;
        bus.core_ready = 1'b0;
        test_reset();
        test_single();
        do_reset();
        test_round_robin();
        test_core_block();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
